// File: rtl/wb_regfile.sv
// Write-back stage and architectural register file: selects the write-back value,
// commits it, serves two bypassed read ports and counts retired instructions.
module wb_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_valid_i,
  input  logic              reg_write_i,
  input  logic              mem_to_reg_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]   alu_res_i,
  input  logic [XLEN-1:0]   read_data_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [XLEN-1:0]   rs1_data_o,
  output logic [XLEN-1:0]   rs2_data_o,
  output logic              wb_en_o,
  output logic [ADDR_W-1:0] wb_rd_o,
  output logic [XLEN-1:0]   wb_data_o,
  output logic [31:0]       retired_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic [31:0]     retired_q;
  logic [31:0]     retired_d;

  always_comb begin
    wb_data_o = alu_res_i;
    if (mem_to_reg_i) begin
      wb_data_o = read_data_i;
    end else begin
      wb_data_o = alu_res_i;
    end
  end

  // Written as an if so an unknown valid/write strobe falls through to "no write".
  always_comb begin
    wb_en_o = 1'b0;
    wb_rd_o = '0;
    if (rst_i && wb_valid_i && reg_write_i && (rd_addr_i != '0)) begin
      wb_en_o = 1'b1;
      wb_rd_o = rd_addr_i;
    end else begin
      wb_en_o = 1'b0;
      wb_rd_o = '0;
    end
  end

  always_comb begin
    rs1_data_o = '0;
    if (rs1_addr_i == '0) begin
      rs1_data_o = '0;
    end else if (wb_en_o && (rs1_addr_i == rd_addr_i)) begin
      rs1_data_o = wb_data_o;
    end else begin
      rs1_data_o = regs_q[rs1_addr_i];
    end
  end

  always_comb begin
    rs2_data_o = '0;
    if (rs2_addr_i == '0) begin
      rs2_data_o = '0;
    end else if (wb_en_o && (rs2_addr_i == rd_addr_i)) begin
      rs2_data_o = wb_data_o;
    end else begin
      rs2_data_o = regs_q[rs2_addr_i];
    end
  end

  // Storage is reset flip-flops, so x0 stays a constant zero.
  always_ff @(posedge clk_i) begin
    regs_q[0] <= '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (!rst_i) begin
        regs_q[i] <= '0;
      end else if (wb_en_o && (rd_addr_i == ADDR_W'(i))) begin
        regs_q[i] <= wb_data_o;
      end else begin
        regs_q[i] <= regs_q[i];
      end
    end
  end

  always_comb begin
    retired_d = retired_q;
    if (!rst_i) begin
      retired_d = 32'd0;
    end else if (wb_valid_i) begin
      retired_d = retired_q + 32'd1;
    end else begin
      retired_d = retired_q;
    end
  end

  always_ff @(posedge clk_i) begin
    retired_q <= retired_d;
  end

  assign retired_o = retired_q;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back stage and architectural register file; the consumer end of the MEM/WB pipeline register. Each cycle it selects the write-back value (ALU result or load data) from the MEM/WB outputs and commits it to the destination register. It serves the two ID-stage read ports with same-cycle write-through bypass. It exports the committed write (enable, rd, data) to the forwarding unit and keeps a retired-instruction counter.

Parameters:
XLEN, 32, data width of registers and write-back datapath
NUM_REGS, 32, number of architectural registers; register 0 hardwired to zero
ADDR_W, 5, register address width; must satisfy 2**ADDR_W == NUM_REGS

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset; synchronous, active-low
wb_valid_i  input  1  MEM/WB slot holds a real instruction (0 = bubble)
reg_write_i  input  1  instruction writes a register
mem_to_reg_i  input  1  1 = write load data, 0 = write ALU result
rd_addr_i  input  ADDR_W  destination register
alu_res_i  input  XLEN  ALU result from MEM/WB
read_data_i  input  XLEN  load data from MEM/WB
rs1_addr_i  input  ADDR_W  ID read port 1 address
rs2_addr_i  input  ADDR_W  ID read port 2 address
rs1_data_o  output  XLEN  read port 1 data (combinational)
rs2_data_o  output  XLEN  read port 2 data (combinational)
wb_en_o  output  1  effective write this cycle (to forwarding unit)
wb_rd_o  output  ADDR_W  destination of effective write
wb_data_o  output  XLEN  selected write-back value
retired_o  output  32  count of valid instructions retired since reset

Behaviour:
- Write select: wb_data_o = mem_to_reg_i ? read_data_i : alu_res_i. This is combinational.
- Effective write: wb_en_o = rst_i & wb_valid_i & reg_write_i & (rd_addr_i != 0).
- wb_rd_o = rd_addr_i when wb_en_o = 1, else 0.
- Commit: on a rising edge with wb_en_o = 1, regs[rd_addr_i] <= wb_data_o. No other register changes.
- Register 0: never written, always reads 0, including under bypass.
- Read port n, combinational:
  - address 0 -> 0
  - else if wb_en_o and address == rd_addr_i -> wb_data_o (write-through bypass, same cycle)
  - else -> regs[address]
- Both read ports are independent. Both may bypass in the same cycle.
- retired_o increments by 1 on each rising edge with rst_i = 1 and wb_valid_i = 1, regardless of reg_write_i or rd.
- retired_o wraps 0xFFFFFFFF -> 0 with no flag.
- Bubbles (wb_valid_i = 0) write nothing, do not count, and force wb_en_o = 0. reg_write_i, mem_to_reg_i and the data inputs are don't-care during a bubble.
- Latency: a write is architecturally visible at read ports in the same cycle via bypass, and from storage from the next cycle.
- Reset (rst_i = 0 at a rising edge):
  - all registers 1..NUM_REGS-1 cleared to 0; retired_o cleared to 0
  - any write or retire presented in that cycle is discarded
  - while rst_i = 0: wb_en_o = 0, wb_rd_o = 0, and reads return stored (cleared) values with no bypass
- Reset asserted mid-stream: the state after the edge is identical to power-on reset.
- Uninitialised MEM/WB outputs (X before the first real instruction) must not corrupt state. Any X on wb_valid_i or reg_write_i must gate as non-write. The bench holds wb_valid_i = 0 until the pipeline is primed.
- Synthesis: storage infers flip-flops (2 async reads, 1 sync write). No reset-less RAM inference.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, assert rst_i for 1 cycle, release -> rs1(x5) = 0, retired_o = 0.
- ALU vs load select: rd = 3, alu_res = 0x11, read_data = 0x22, mem_to_reg = 1 -> x3 = 0x22 next cycle; repeat with mem_to_reg = 0 -> x3 = 0x11.
- x0 protection: valid write rd = 0, data = 0xFFFFFFFF -> wb_en_o = 0, rs1(x0) = 0, retired_o increments by 1.
- Bypass: same cycle, write rd = 7 data 0xCAFE0001, rs1 = rs2 = 7 -> both outputs 0xCAFE0001 before the edge; storage holds it after the edge.
- Bubble: wb_valid_i = 0, reg_write_i = 1, rd = 9, data 0x55 -> x9 unchanged, wb_en_o = 0, retired_o unchanged.
- Counter wrap and reset mid-op: preload retired_o to 0xFFFFFFFF (100 cycles after force), one valid cycle -> 0. Then rst_i = 0 in the same cycle as a write to x4 -> x4 stays 0.
